hazard_scoreboard_unit: RTL and testbench

- Parametrised successor to the decode-stage hazard detector.
- Tracks in-flight register writes in an internal shift register, one slot per pipeline stage between ID and WB.
- Raises a combinational stall request for the instruction in ID.
- Adds features the previous block lacked:
  - configurable source count and register width;
  - configurable pipeline depth;
  - load-use-only stalling when forwarding is enabled;
  - freeze/flush handling;
  - a saturating stall counter.

---
 rtl/hazard_scoreboard_unit.sv | 130 +++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_unit
//
// Decode-stage hazard scoreboard. Every instruction that leaves ID and writes
// a register is recorded in a small shift register with one slot per stage
// between ID and WB (slot 0 = EXE, slot 1 = MEM, ...). The sources of the
// instruction currently in ID are compared against these slots to produce a
// zero-latency stall request.
//
// Ports:
//   clk               in   rising-edge clock
//   rst               in   synchronous active-low reset
//   freeze            in   pipeline held, slots do not advance
//   flush             in   branch taken, every slot is invalidated
//   forwardingEnabled in   1 = stall on load-use only, 0 = stall on any RAW
//   issueValid        in   ID holds a real instruction
//   srcValid          in   per-source compare enable   [NUM_SRC]
//   src               in   packed sources, i at [i*W +: W]
//   writeBackEnabled  in   ID instruction writes a register
//   destination       in   ID destination register
//   memRead           in   ID instruction is a load
//   hazard            out  combinational stall request
//   hazardCount       out  saturating count of stalled issue cycles
//   pendingValid      out  valid bit of every slot (debug)
// ---------------------------------------------------------------------------
module hazard_scoreboard_unit #(
   parameter int REG_ADDR_WIDTH = 4,
   parameter int NUM_SRC        = 2,
   parameter int PIPE_DEPTH     = 2,
   parameter int LOAD_USE_SLOTS = 1,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              freeze,
   input  logic                              flush,
   input  logic                              forwardingEnabled,
   input  logic                              issueValid,
   input  logic [NUM_SRC-1:0]                srcValid,
   input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] src,
   input  logic                              writeBackEnabled,
   input  logic [REG_ADDR_WIDTH-1:0]         destination,
   input  logic                              memRead,
   output logic                              hazard,
   output logic [CNT_WIDTH-1:0]              hazardCount,
   output logic [PIPE_DEPTH-1:0]             pendingValid
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [PIPE_DEPTH-1:0]     slotValid_q, slotValid_d;
   logic [PIPE_DEPTH-1:0]     slotLoad_q, slotLoad_d;
   logic [REG_ADDR_WIDTH-1:0] slotDest_q [PIPE_DEPTH];
   logic [REG_ADDR_WIDTH-1:0] slotDest_d [PIPE_DEPTH];
   logic [CNT_WIDTH-1:0]      hazardCount_q, hazardCount_d;
   logic                      rawHit;

   // Source/slot comparison. With forwarding on, only a load that has not yet
   // reached the first forwarding point (slots below LOAD_USE_SLOTS) can
   // still stall. The ID destination is deliberately never compared here.
   always_comb begin
      rawHit = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            if (srcValid[i] && slotValid_q[k] &&
                (src[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == slotDest_q[k])) begin
               if (!forwardingEnabled) begin
                  rawHit = 1'b1;
               end else if (slotLoad_q[k] && (k < LOAD_USE_SLOTS)) begin
                  rawHit = 1'b1;
               end
            end
         end
      end
      hazard = issueValid & rawHit;
   end

   // Slot next state. Flush wins over freeze; a stalled ID instruction enters
   // slot 0 as a bubble because it is being held upstream.
   always_comb begin
      slotValid_d = slotValid_q;
      slotLoad_d  = slotLoad_q;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
         slotDest_d[k] = slotDest_q[k];
      end
      if (flush) begin
         slotValid_d = '0;
      end else if (!freeze) begin
         for (int k = PIPE_DEPTH - 1; k > 0; k--) begin
            slotValid_d[k] = slotValid_q[k-1];
            slotLoad_d[k]  = slotLoad_q[k-1];
            slotDest_d[k]  = slotDest_q[k-1];
         end
         slotValid_d[0] = issueValid & ~hazard & writeBackEnabled;
         slotLoad_d[0]  = memRead;
         slotDest_d[0]  = destination;
      end
   end

   // Stall counter only counts cycles where the stall actually costs an
   // issue slot, and it sticks at its maximum instead of wrapping.
   always_comb begin
      hazardCount_d = hazardCount_q;
      if (hazard && !freeze && !flush && (hazardCount_q != CNT_MAX)) begin
         hazardCount_d = hazardCount_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         slotValid_q   <= '0;
         slotLoad_q    <= '0;
         hazardCount_q <= '0;
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            slotDest_q[k] <= '0;
         end
      end else begin
         slotValid_q   <= slotValid_d;
         slotLoad_q    <= slotLoad_d;
         hazardCount_q <= hazardCount_d;
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            slotDest_q[k] <= slotDest_d[k];
         end
      end
   end

   assign hazardCount  = hazardCount_q;
   assign pendingValid = slotValid_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard_unit
//
// Drives two scoreboards (default counter width and a 2-bit counter) from the
// same stimulus and compares them every cycle against a queue-based model of
// the in-flight writers, plus a few directed scenario expectations.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard_unit;

   localparam int W   = 4;
   localparam int NS  = 2;
   localparam int PD  = 2;
   localparam int LUS = 1;

   typedef struct packed {
      logic         valid;
      logic [W-1:0] dest;
      logic         load;
   } entry_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            freeze;
   logic            flush;
   logic            forwardingEnabled;
   logic            issueValid;
   logic [NS-1:0]   srcValid;
   logic [NS*W-1:0] src;
   logic            writeBackEnabled;
   logic [W-1:0]    destination;
   logic            memRead;
   logic            hazard;
   logic            hazardSat;
   logic [15:0]     hazardCount;
   logic [1:0]      hazardCountSat;
   logic [PD-1:0]   pendingValid;
   logic [PD-1:0]   pendingValidSat;

   int     errors = 0;
   int     checks = 0;
   int     modelCount;
   int     modelCountSat;
   entry_t inflight[$];
   logic   lastHaz;
   int     base;

   always #5 clk = ~clk;

   hazard_scoreboard_unit #(
      .REG_ADDR_WIDTH(W), .NUM_SRC(NS), .PIPE_DEPTH(PD),
      .LOAD_USE_SLOTS(LUS), .CNT_WIDTH(16)
   ) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .forwardingEnabled(forwardingEnabled), .issueValid(issueValid),
      .srcValid(srcValid), .src(src), .writeBackEnabled(writeBackEnabled),
      .destination(destination), .memRead(memRead), .hazard(hazard),
      .hazardCount(hazardCount), .pendingValid(pendingValid)
   );

   hazard_scoreboard_unit #(
      .REG_ADDR_WIDTH(W), .NUM_SRC(NS), .PIPE_DEPTH(PD),
      .LOAD_USE_SLOTS(LUS), .CNT_WIDTH(2)
   ) dutSat (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .forwardingEnabled(forwardingEnabled), .issueValid(issueValid),
      .srcValid(srcValid), .src(src), .writeBackEnabled(writeBackEnabled),
      .destination(destination), .memRead(memRead), .hazard(hazardSat),
      .hazardCount(hazardCountSat), .pendingValid(pendingValidSat)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drives all inputs at once; called just after a falling edge.
   task automatic applyStimulus(input logic r, input logic fz, input logic fl,
                                input logic fwd, input logic iv,
                                input logic [NS-1:0] sv, input logic [W-1:0] s0,
                                input logic [W-1:0] s1, input logic wb,
                                input logic [W-1:0] d, input logic ld);
      rst               = r;
      freeze            = fz;
      flush             = fl;
      forwardingEnabled = fwd;
      issueValid        = iv;
      srcValid          = sv;
      src               = {s1, s0};
      writeBackEnabled  = wb;
      destination       = d;
      memRead           = ld;
   endtask

   // Model: the in-flight writers, youngest first, one entry per stage.
   function automatic void modelClear();
      entry_t e;
      e = '0;
      inflight = {};
      for (int k = 0; k < PD; k++) inflight.push_back(e);
      modelCount    = 0;
      modelCountSat = 0;
   endfunction

   function automatic logic modelHazard();
      logic   h;
      logic [W-1:0] s;
      h = 1'b0;
      if (issueValid) begin
         for (int i = 0; i < NS; i++) begin
            s = src[i*W +: W];
            for (int k = 0; k < PD; k++) begin
               if (srcValid[i] && inflight[k].valid && (s == inflight[k].dest)) begin
                  if (!forwardingEnabled || (inflight[k].load && k < LUS)) h = 1'b1;
               end
            end
         end
      end
      return h;
   endfunction

   function automatic logic [31:0] modelPending();
      logic [31:0] p;
      p = '0;
      for (int k = 0; k < PD; k++) p[k] = inflight[k].valid;
      return p;
   endfunction

   function automatic void modelUpdate(input logic h);
      entry_t e;
      if (!rst) begin
         modelClear();
      end else begin
         if (h && !freeze && !flush) begin
            if (modelCount < 65535) modelCount++;
            if (modelCountSat < 3) modelCountSat++;
         end
         if (flush) begin
            for (int k = 0; k < PD; k++) inflight[k].valid = 1'b0;
         end else if (!freeze) begin
            e.valid = issueValid & ~h & writeBackEnabled;
            e.dest  = destination;
            e.load  = memRead;
            inflight.push_front(e);
            void'(inflight.pop_back());
         end
      end
   endfunction

   // One clock: compare everything against the model, then step the model
   // with the inputs seen at the rising edge.
   task automatic runCycle();
      logic expHaz;
      #1;
      expHaz  = modelHazard();
      lastHaz = hazard;
      checkOutput("hazard", {31'd0, hazard}, {31'd0, expHaz});
      checkOutput("hazardSat", {31'd0, hazardSat}, {31'd0, expHaz});
      checkOutput("pendingValid", {30'd0, pendingValid}, modelPending());
      checkOutput("pendingValidSat", {30'd0, pendingValidSat}, modelPending());
      checkOutput("hazardCount", {16'd0, hazardCount}, modelCount);
      checkOutput("hazardCountSat", {30'd0, hazardCountSat}, modelCountSat);
      @(posedge clk);
      modelUpdate(expHaz);
      @(negedge clk);
   endtask

   initial begin
      modelClear();
      applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      runCycle();

      // Scenario 1: ALU producer R3, no forwarding, stall for PD cycles.
      applyStimulus(1, 0, 0, 0, 1, 2'b00, 0, 0, 1, 3, 0);
      runCycle();
      base = modelCount;
      applyStimulus(1, 0, 0, 0, 1, 2'b01, 3, 0, 0, 0, 0);
      runCycle(); checkOutput("s1_stall0", {31'd0, lastHaz}, 1);
      runCycle(); checkOutput("s1_stall1", {31'd0, lastHaz}, 1);
      runCycle(); checkOutput("s1_release", {31'd0, lastHaz}, 0);
      checkOutput("s1_count", {16'd0, hazardCount}, base + 2);

      // Scenario 2: same with forwarding, no stall.
      applyStimulus(1, 0, 0, 1, 1, 2'b00, 0, 0, 1, 3, 0);
      runCycle();
      base = modelCount;
      applyStimulus(1, 0, 0, 1, 1, 2'b01, 3, 0, 0, 0, 0);
      for (int c = 0; c < 3; c++) begin
         runCycle(); checkOutput("s2_nostall", {31'd0, lastHaz}, 0);
      end
      checkOutput("s2_count", {16'd0, hazardCount}, base);

      // Scenario 3: load-use on source 1.
      applyStimulus(1, 0, 0, 1, 1, 2'b00, 0, 0, 1, 5, 1);
      runCycle();
      applyStimulus(1, 0, 0, 1, 1, 2'b10, 0, 5, 0, 0, 0);
      runCycle(); checkOutput("s3_loaduse", {31'd0, lastHaz}, 1);
      runCycle(); checkOutput("s3_release", {31'd0, lastHaz}, 0);

      // Scenario 4: freeze while stalled.
      applyStimulus(1, 0, 0, 0, 1, 2'b00, 0, 0, 1, 3, 0);
      runCycle();
      base = modelCount;
      applyStimulus(1, 1, 0, 0, 1, 2'b01, 3, 0, 0, 0, 0);
      for (int c = 0; c < 3; c++) begin
         runCycle();
         checkOutput("s4_frozen_haz", {31'd0, lastHaz}, 1);
         checkOutput("s4_frozen_pv", {30'd0, pendingValid}, 32'h1);
         checkOutput("s4_frozen_cnt", {16'd0, hazardCount}, base);
      end
      applyStimulus(1, 0, 0, 0, 1, 2'b01, 3, 0, 0, 0, 0);
      runCycle(); runCycle();
      runCycle(); checkOutput("s4_release", {31'd0, lastHaz}, 0);
      checkOutput("s4_count", {16'd0, hazardCount}, base + 2);

      // Scenario 5: flush beats the issue of R7.
      applyStimulus(1, 0, 0, 0, 1, 2'b00, 0, 0, 1, 2, 0);
      runCycle();
      applyStimulus(1, 0, 0, 0, 1, 2'b00, 0, 0, 1, 4, 0);
      runCycle();
      checkOutput("s5_full", {30'd0, pendingValid}, 32'h3);
      applyStimulus(1, 0, 1, 0, 1, 2'b00, 0, 0, 1, 7, 0);
      runCycle();
      checkOutput("s5_flushed", {30'd0, pendingValid}, 32'h0);
      applyStimulus(1, 0, 0, 0, 1, 2'b01, 7, 0, 0, 0, 0);
      runCycle(); checkOutput("s5_nohaz", {31'd0, lastHaz}, 0);

      // Randomised traffic over a small register range to force hits.
      for (int n = 0; n < 400; n++) begin
         applyStimulus(($urandom_range(0, 29) != 0), ($urandom_range(0, 5) == 0),
                       ($urandom_range(0, 9) == 0), 1'($urandom),
                       ($urandom_range(0, 7) != 0), 2'($urandom),
                       4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                       1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom));
         runCycle();
      end

      // Scenario 6: repeated producer/consumer pairs saturate the 2-bit count.
      applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      runCycle();
      for (int r = 0; r < 3; r++) begin
         applyStimulus(1, 0, 0, 0, 1, 2'b00, 0, 0, 1, 1, 0);
         runCycle();
         applyStimulus(1, 0, 0, 0, 1, 2'b01, 1, 0, 0, 0, 0);
         runCycle(); runCycle(); runCycle();
      end
      checkOutput("s6_sat", {30'd0, hazardCountSat}, 3);
      checkOutput("s6_wide", {16'd0, hazardCount}, 6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
